// File: rtl/alu_iter.sv
// alu_iter: registered ALU behind a valid/ready handshake. Defining ALU_ITER_MULDIV_EN
// adds iterative MUL/DIVU/REMU (one shift-add / restoring-subtract step per cycle).
module alu_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic [3:0]   sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res,
    output logic         zf,
    output logic         ovf
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] res_q, res_d;
    logic         zf_q, zf_d;
    logic         ovf_q, ovf_d;

    // Returns {ovf, res}; unlisted codes (and iterative codes without the option) give zero.
    function automatic logic [W:0] single_op(input logic [3:0] code,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         v;
        r = '0;
        v = 1'b0;
        case (code)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD: begin
                r = a + b;
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                r = a - b;
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SLTU: r = {{(W-1){1'b0}}, (a < b)};
            OP_SLT:  r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  r = ~(a | b);
            default: r = '0;
        endcase
        return {v, r};
    endfunction

`ifdef ALU_ITER_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;
    localparam int         CW      = $clog2(W) + 1;

    // kind: 01 MUL, 10 DIVU, 11 REMU. MUL: a=multiplicand, b=multiplier, acc=product.
    // DIV: a=dividend shifting into quotient, b=divisor, acc=partial remainder.
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [1:0]    kind_q, kind_d;
    logic [W:0]    trial;
    logic          ge;
    logic [W-1:0]  step_a, step_acc;

    always_comb begin
        trial    = {acc_q, a_q[W-1]};
        ge       = trial >= {1'b0, b_q};
        step_a   = a_q;
        step_acc = acc_q;
        if (kind_q == 2'b01) begin
            step_acc = acc_q + (b_q[0] ? a_q : '0);
            step_a   = a_q << 1;
        end else begin
            // When ge holds the difference is below b_q, so W bits suffice.
            step_acc = ge ? (trial[W-1:0] - b_q) : trial[W-1:0];
            step_a   = {a_q[W-2:0], ge};
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zf_d    = zf_q;
        ovf_d   = ovf_q;
`ifdef ALU_ITER_MULDIV_EN
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        kind_d  = kind_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_ITER_MULDIV_EN
                    if (sel == OP_MUL || sel == OP_DIVU || sel == OP_REMU) begin
                        kind_d  = sel[1:0];
                        a_d     = op1;
                        b_d     = op2;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else
`endif
                    begin
                        {ovf_d, res_d} = single_op(sel, op1, op2);
                        zf_d           = ~|res_d;
                        state_d        = DONE;
                    end
                end
            end
            BUSY: begin
`ifdef ALU_ITER_MULDIV_EN
                a_d   = step_a;
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (kind_q == 2'b01) begin
                    b_d = b_q >> 1;
                end
                if (cnt_q == CW'(W - 1)) begin
                    res_d   = (kind_q == 2'b10) ? step_a : step_acc;
                    zf_d    = ~|res_d;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            zf_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ALU_ITER_MULDIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            kind_q <= 2'b00;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            kind_q <= kind_d;
        end
    end
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign zf        = zf_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: directed vectors with literal results, plus a per-cycle
// reference model check of handshake, latency and res/zf/ovf.
module tb_alu_iter;
    localparam int W = 32;
`ifdef ALU_ITER_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [3:0]   sel = 4'h0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res;
    logic         zf;
    logic         ovf;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_iter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .zf(zf), .ovf(ovf)
    );

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         v;
        int           due;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting on handshake", name);
    endtask

    // Reference: plain arithmetic on the operation's meaning; due holds the latency.
    function automatic exp_t model(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic signed [W:0] wide;
        e.r = '0;
        e.v = 1'b0;
        e.due = 0;
        case (s)
            4'h0: e.r = a & b;
            4'h1: e.r = a | b;
            4'h2: begin
                wide = $signed({a[W-1], a}) + $signed({b[W-1], b});
                e.r = wide[W-1:0];
                e.v = (wide[W] != wide[W-1]);
            end
            4'h6: begin
                wide = $signed({a[W-1], a}) - $signed({b[W-1], b});
                e.r = wide[W-1:0];
                e.v = (wide[W] != wide[W-1]);
            end
            4'h7: e.r = (a < b) ? W'(1) : '0;
            4'h8: e.r = ($signed(a) < $signed(b)) ? W'(1) : '0;
            4'hC: e.r = ~(a | b);
            4'h9: if (MD) begin e.r = a * b; e.due = W; end
            4'hA: if (MD) begin e.r = (b == '0) ? '1 : a / b; e.due = W; end
            4'hB: if (MD) begin e.r = (b == '0) ? a : a % b; e.due = W; end
            default: e.r = '0;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_res", 64'(res), 64'd0);
            chk("rst_zf", 64'(zf), 64'd0);
            chk("rst_ovf", 64'(ovf), 64'd0);
            q.delete();
        end else begin
            if (q.size() == 0) begin
                chk("idle_in_ready", 64'(in_ready), 64'd1);
                chk("idle_out_valid", 64'(out_valid), 64'd0);
            end else if (cyc < q[0].due) begin
                chk("busy_out_valid", 64'(out_valid), 64'd0);
                chk("busy_in_ready", 64'(in_ready), 64'd0);
            end else begin
                chk("done_out_valid", 64'(out_valid), 64'd1);
                chk("done_in_ready", 64'(in_ready), 64'd0);
                chk("model_res", 64'(res), 64'(q[0].r));
                chk("model_zf", 64'(zf), 64'(q[0].z));
                chk("model_ovf", 64'(ovf), 64'(q[0].v));
                if (out_valid && out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                e = model(sel, op1, op2);
                e.due = cyc + 1 + e.due;
                q.push_back(e);
            end
        end
    end

    task automatic run(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_res, input int hold, input string name);
        bit got;
        @(posedge clk); #1;
        sel = s; op1 = a; op2 = b; in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) begin
            timeout({name, "_accept"});
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op1 = $urandom; op2 = $urandom; sel = 4'($urandom);
        got = 1'b0;
        for (int i = 0; i < W + 5 && !got; i++) begin
            @(negedge clk);
            got = out_valid;
        end
        if (!got) begin
            timeout({name, "_result"});
            return;
        end
        chk(name, 64'(res), 64'(exp_res));
        @(posedge clk); #1;
        if (hold > 0) begin
            in_valid = 1'b1;
            repeat (hold) @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        run(4'h2, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, "add_ovf");
        run(4'h6, 32'd5, 32'd5, 32'd0, 0, "sub_zero");
        run(4'h6, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, "sub_ovf");
        run(4'h8, 32'hFFFFFFFF, 32'h1, 32'd1, 0, "slt");
        run(4'h7, 32'hFFFFFFFF, 32'h1, 32'd0, 0, "sltu");
        run(4'hC, 32'h0, 32'h0, 32'hFFFFFFFF, 0, "nor");
        run(4'h0, 32'hF0F0, 32'hFF00, 32'hF000, 0, "and");
        run(4'h1, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, "or");
        run(4'h3, 32'd5, 32'd6, 32'd0, 0, "unlisted");
        run(4'h9, 32'd7, 32'd6, MD ? 32'd42 : 32'd0, 0, "mul");
        run(4'h9, 32'hFFFFFFFF, 32'd2, MD ? 32'hFFFFFFFE : 32'd0, 0, "mul_wrap");
        run(4'hA, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, 0, "divu");
        run(4'hB, 32'd100, 32'd7, MD ? 32'd2 : 32'd0, 0, "remu");
        run(4'hA, 32'd9, 32'd0, MD ? 32'hFFFFFFFF : 32'd0, 0, "divu_zero");
        run(4'hB, 32'd9, 32'd0, MD ? 32'd9 : 32'd0, 0, "remu_zero");
        run(4'h2, 32'd1, 32'd2, 32'd3, 10, "add_hold");

        // Abort an in-flight MUL with an asynchronous reset mid-cycle.
        @(posedge clk); #1;
        sel = 4'h9; op1 = 32'd7; op2 = 32'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_res", 64'(res), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        run(4'h2, 32'd2, 32'd3, 32'd5, 0, "add_after_abort");
        run(4'h9, 32'd3, 32'd4, MD ? 32'd12 : 32'd0, 0, "mul_after_abort");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
